md5_stream: RTL and testbench
=============================

Name: md5_stream

Overview:
- Parametrised successor to the single-message MD5 engine. Computes MD5 over a stream of 512-bit blocks delivered by a valid/ready handshake.
- Per-block first/last framing replaces the constant block-count input.
- The chaining value can be loaded from an external IV, e.g. precomputed HMAC ipad/opad midstates.
- Configurable round unrolling. Sits between the HMAC controller and the block buffer in the uncore.

Parameters:
- UNROLL, 1, MD5 steps per compute cycle; legal values 1, 2, 4, 8. Any other value is a elaboration error.
- CNT_W, 32, width of the block counter output.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- blk_valid  input  1  block offered
- blk_ready  output  1  engine can accept a block
- blk_data  input  512  block; word i = blk_data[32i+:32], little-endian bytes (byte 0 = blk_data[7:0])
- blk_first  input  1  block starts a new message (qualified by blk_valid)
- blk_last  input  1  block ends the message
- iv_sel  input  1  with blk_first: 1 = chain starts from iv_in, 0 = standard MD5 IV
- iv_in  input  128  custom IV {A,B,C,D}
- block_cnt  output  CNT_W  blocks accepted in the current message
- digest_valid  output  1  digest available
- digest_ready  input  1  consumer takes digest
- digest  output  128  {a0,b0,c0,d0}, raw word order

Behaviour:
- Reset (async, rst=0): state S_IDLE, blk_ready=1, digest_valid=0, digest=0, block_cnt=0, chain = standard IV {67452301, efcdab89, 98badcfe, 10325476}, in_msg=0.
- States: S_IDLE, S_COMPUTE, S_FINAL, S_OUT.
- S_IDLE: blk_ready=1.
  - On handshake: latch blk_data into message registers and latch blk_last.
  - If blk_first=1: chain and working regs A..D load from iv_in (iv_sel=1) or the standard IV (iv_sel=0); block_cnt<=1.
  - Else: working regs load from the chain; block_cnt<=block_cnt+1 (wraps modulo 2^CNT_W).
  - A block with blk_first=0 when in_msg=0 is treated as first with standard IV.
  - blk_first=1 while in_msg=1 abandons the old chain silently.
  - Go to S_COMPUTE with step counter=0.
- S_COMPUTE: blk_ready=0.
  - Each cycle applies UNROLL consecutive MD5 steps combinationally: F/G/H/I by round, K[i], s[i], g[i].
  - Step update: A'=D, D'=C, C'=B, B'=B+rotl(A+F+K+M[g], s).
  - Counter advances by UNROLL. After the cycle processing step 63 (64/UNROLL cycles), go to S_FINAL.
  - All additions are modulo 2^32.
- S_FINAL, one cycle: chain <= chain + {A,B,C,D} per word.
  - If the latched last=1: digest <= new chain, digest_valid<=1, in_msg<=0, go to S_OUT.
  - Else: in_msg<=1, go to S_IDLE.
- S_OUT: blk_ready=0; digest_valid and digest held stable until digest_ready=1. That cycle: digest_valid<=0, go to S_IDLE. digest_ready while digest_valid=0 is ignored.
- Latency: handshake at cycle T → S_FINAL at T+64/UNROLL+1 → digest_valid at T+64/UNROLL+2 (UNROLL=1: 66 cycles).
- Throughput: one block per 64/UNROLL+2 cycles when blk_valid is held.
- blk_data and framing inputs are sampled only on the handshake cycle and may change afterwards.
- digest retains its value after S_OUT until the next last block completes.
- block_cnt holds its value after the message ends, until the next accepted block.
- Reset mid-operation aborts immediately to reset values; no partial digest is emitted.

Decomposition:
- Package md5_pkg contains:
  - 64-entry K table, shift table and message-index table as localparam arrays;
  - IV localparams;
  - state enum typedef;
  - function returning round function F given round index and B/C/D.
- Sub-module md5_step: purely combinational single step.
  - Inputs: A/B/C/D, step index, 16-word message.
  - Outputs: next A/B/C/D.
  - Instantiated UNROLL times in a generate chain.

Test Plan:
1. UNROLL=1, one block, blk_first=blk_last=1, iv_sel=0; empty message (word0=32'h00000080, others 0) → digest=128'hd98c1dd4_04b2008f_980980e9_7e42f8ec, digest_valid at handshake+66, block_cnt=1.
2. "abc" (word0=32'h80636261, word14=32'h18) for UNROLL=1,2,4,8 → digest=128'h98500190_b04fd23c_7d3f96d6_727fe128 in every config; latency 64/UNROLL+2.
3. Two-block 64-byte "a"×64 message, blocks back-to-back with blk_valid held → blk_ready low during compute; block_cnt=2; digest equals the reference model (MD5 = 014842d480b571495a4a0363793f7367); second block accepted at first handshake+66.
4. iv_sel=1 with iv_in = midstate produced by test 3's first block, sending only the second block as first+last → same digest as test 3.
5. Hold digest_ready=0 for 20 cycles → digest_valid and digest stable, blk_ready=0; pulse digest_ready → valid drops the next cycle, blk_ready=1.
6. Assert rst=0 mid-compute of "abc", release, resend "abc" → no digest_valid during or after abort; correct digest after resend; a blk_first=1 block sent while in_msg=1 restarts the chain, giving the "abc" digest.

Source files
------------

// File: rtl/md5_pkg.sv
// ============================================================================
// md5_pkg : MD5 round constants, standard IV, FSM encodings, round function
// Revision: 1.0
// ============================================================================
`default_nettype none

package md5_pkg;

  localparam logic [127:0] IV_STD = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_COMPUTE = 2'd1;
  localparam state_t S_FINAL   = 2'd2;
  localparam state_t S_OUT     = 2'd3;

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TABLE [0:63] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  // Message word consumed by each step
  localparam logic [3:0] G_TABLE [0:63] = '{
    4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
    4'd1,  4'd6,  4'd11, 4'd0,  4'd5,  4'd10, 4'd15, 4'd4,
    4'd9,  4'd14, 4'd3,  4'd8,  4'd13, 4'd2,  4'd7,  4'd12,
    4'd5,  4'd8,  4'd11, 4'd14, 4'd1,  4'd4,  4'd7,  4'd10,
    4'd13, 4'd0,  4'd3,  4'd6,  4'd9,  4'd12, 4'd15, 4'd2,
    4'd0,  4'd7,  4'd14, 4'd5,  4'd12, 4'd3,  4'd10, 4'd1,
    4'd8,  4'd15, 4'd6,  4'd13, 4'd4,  4'd11, 4'd2,  4'd9
  };

  function automatic logic [31:0] round_f(input logic [1:0] round,
                                          input logic [31:0] b,
                                          input logic [31:0] c,
                                          input logic [31:0] d);
    case (round)
      2'd0:    return (b & c) | (~b & d);
      2'd1:    return (b & d) | (c & ~d);
      2'd2:    return b ^ c ^ d;
      default: return c ^ (b | ~d);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/md5_step.sv
// ============================================================================
// md5_step : one combinational MD5 step
// Revision: 1.0
// ============================================================================
`default_nettype none

module md5_step
  import md5_pkg::*;
(
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [5:0]   idx,
  input  logic [511:0] msg,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);

  logic [31:0] f;
  logic [31:0] m;
  logic [31:0] sum;
  logic [4:0]  s;
  logic [31:0] rot;

  assign f     = round_f(idx[5:4], b_in, c_in, d_in);
  assign m     = msg[{G_TABLE[idx], 5'd0} +: 32];
  assign sum   = a_in + f + K_TABLE[idx] + m;
  assign s     = S_TABLE[idx];
  // Shift amounts are never zero, so the right shift never reaches 32
  assign rot   = (sum << s) | (sum >> (6'd32 - {1'b0, s}));

  assign a_out = d_in;
  assign b_out = b_in + rot;
  assign c_out = b_in;
  assign d_out = c_in;

endmodule

`default_nettype wire

// File: rtl/md5_stream.sv
// ============================================================================
// md5_stream : streaming MD5 over framed 512-bit blocks, loadable IV
// Revision: 1.0
// ============================================================================
`default_nettype none

module md5_stream
  import md5_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic             iv_sel,
  input  logic [127:0]     iv_in,
  output logic [CNT_W-1:0] block_cnt,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [127:0]     digest
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("md5_stream: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] LAST_STEP = 6'(64 - UNROLL);

  state_t       state;
  logic [5:0]   step_cnt;
  logic [31:0]  wa, wb, wc, wd;
  logic [127:0] chain;
  logic [511:0] msg_q;
  logic         last_q;
  logic         in_msg;

  logic [127:0] start_iv;
  logic [127:0] chain_sum;
  logic [31:0]  sa [0:UNROLL];
  logic [31:0]  sb [0:UNROLL];
  logic [31:0]  sc [0:UNROLL];
  logic [31:0]  sd [0:UNROLL];

  assign blk_ready = (state == S_IDLE);
  assign start_iv  = (blk_first && iv_sel) ? iv_in : IV_STD;
  assign chain_sum = {chain[127:96] + wa, chain[95:64] + wb,
                      chain[63:32]  + wc, chain[31:0]  + wd};

  assign sa[0] = wa;
  assign sb[0] = wb;
  assign sc[0] = wc;
  assign sd[0] = wd;

  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    md5_step u_step (
      .a_in  (sa[u]),
      .b_in  (sb[u]),
      .c_in  (sc[u]),
      .d_in  (sd[u]),
      .idx   (step_cnt + 6'(u)),
      .msg   (msg_q),
      .a_out (sa[u+1]),
      .b_out (sb[u+1]),
      .c_out (sc[u+1]),
      .d_out (sd[u+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      step_cnt     <= '0;
      wa           <= '0;
      wb           <= '0;
      wc           <= '0;
      wd           <= '0;
      chain        <= IV_STD;
      msg_q        <= '0;
      last_q       <= 1'b0;
      in_msg       <= 1'b0;
      block_cnt    <= '0;
      digest_valid <= 1'b0;
      digest       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_valid) begin
            msg_q    <= blk_data;
            last_q   <= blk_last;
            step_cnt <= '0;
            state    <= S_COMPUTE;
            // A continuation block with no open message starts a fresh chain
            if (blk_first || !in_msg) begin
              chain             <= start_iv;
              {wa, wb, wc, wd}  <= start_iv;
              block_cnt         <= CNT_W'(1);
            end else begin
              {wa, wb, wc, wd}  <= chain;
              block_cnt         <= block_cnt + CNT_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          wa       <= sa[UNROLL];
          wb       <= sb[UNROLL];
          wc       <= sc[UNROLL];
          wd       <= sd[UNROLL];
          step_cnt <= step_cnt + 6'(UNROLL);
          if (step_cnt == LAST_STEP) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          chain <= chain_sum;
          if (last_q) begin
            digest       <= chain_sum;
            digest_valid <= 1'b1;
            in_msg       <= 1'b0;
            state        <= S_OUT;
          end else begin
            in_msg <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md5_stream.sv
// ============================================================================
// tb_md5_stream : self-checking bench over UNROLL = 1, 2, 4, 8 instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_md5_stream;

  localparam logic [127:0] IV_STD  = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam logic [127:0] D_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] D_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  localparam logic [127:0] D_A64   = 128'hd4424801_4971b580_63034a5a_67733f79;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   valid_v;
  logic [3:0]   ready_v;
  logic [3:0]   dv_v;
  logic [3:0]   dr_v;
  logic [3:0]   dv_prev;
  logic [511:0] blk_data;
  logic         blk_first, blk_last, iv_sel;
  logic [127:0] iv_in;
  logic [31:0]  cnt_v [4];
  logic [127:0] dig_v [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           inst;
    logic [127:0] dig;
    int           due;
    string        name;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  typedef struct {
    int           inst;
    logic [511:0] data;
    logic [127:0] dig;
    string        name;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    md5_stream #(.UNROLL(1 << k), .CNT_W(32)) u_dut (
      .clk          (clk),
      .rst          (rst_n),
      .blk_valid    (valid_v[k]),
      .blk_ready    (ready_v[k]),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .iv_sel       (iv_sel),
      .iv_in        (iv_in),
      .block_cnt    (cnt_v[k]),
      .digest_valid (dv_v[k]),
      .digest_ready (dr_v[k]),
      .digest       (dig_v[k])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent MD5 compression model (K derived from sine)
  function automatic int shamt(input int i);
    int c;
    c = i % 4;
    case (i / 16)
      0:       return (c == 0) ? 7 : (c == 1) ? 12 : (c == 2) ? 17 : 22;
      1:       return (c == 0) ? 5 : (c == 1) ? 9  : (c == 2) ? 14 : 20;
      2:       return (c == 0) ? 4 : (c == 1) ? 11 : (c == 2) ? 16 : 23;
      default: return (c == 0) ? 6 : (c == 1) ? 10 : (c == 2) ? 15 : 21;
    endcase
  endfunction

  function automatic logic [127:0] md5_model(input logic [127:0] iv, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, t, k, tmp;
    int g, s;
    real x;
    a = iv[127:96]; b = iv[95:64]; c = iv[63:32]; d = iv[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      k = 32'(longint'($floor(x * 4294967296.0)));
      s = shamt(i);
      t = a + f + k + blk[g*32 +: 32];
      tmp = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
      a = tmp;
    end
    return {iv[127:96] + a, iv[95:64] + b, iv[63:32] + c, iv[31:0] + d};
  endfunction

  function automatic logic [511:0] mk_blk(input logic [31:0] w0, input logic [31:0] w14);
    logic [511:0] blk;
    blk = '0;
    blk[31:0] = w0;
    blk[14*32 +: 32] = w14;
    return blk;
  endfunction

  // Scoreboard side: every rising digest_valid pops one expectation
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_n && dv_v[k] && !dv_prev[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_digest inst=%0d got %h expected none", k, dig_v[k]);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_inst"}, k, e.inst);
          chk(e.name, dig_v[k], e.dig);
          chk({e.name, "_latency"}, cyc, e.due);
        end
      end
    end
    dv_prev <= dv_v;
  end

  // Called at a negedge; returns at the negedge following the handshake
  task automatic send(input int k, input logic [511:0] data, input logic first, input logic last,
                      input logic ivs, input logic [127:0] iv, input bit push,
                      input logic [127:0] exp_dig, input string name, output int hs);
    blk_data = data; blk_first = first; blk_last = last; iv_sel = ivs; iv_in = iv;
    valid_v[k] = 1'b1;
    hs = -1;
    for (int n = 0; n < 300; n++) begin
      if (ready_v[k]) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_handshake_timeout got no ready expected ready", name);
      valid_v[k] = 1'b0;
      return;
    end
    if (push) exp_q.push_back('{inst: k, dig: exp_dig, due: hs + 64 / (1 << k) + 2, name: name});
    @(negedge clk);
    valid_v[k] = 1'b0;
    blk_data = {16{32'hdeadbeef}};
    blk_first = 1'b0; blk_last = 1'b0; iv_sel = 1'b1; iv_in = '1;
  endtask

  task automatic wait_dv(input int k, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (dv_v[k]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_digest_timeout got no digest_valid expected digest_valid", name);
    end
  endtask

  initial begin
    logic [511:0] blk_a, blk_pad, blk_abc;
    logic [127:0] mid;
    int hs1, hs2, bad;

    blk_a   = {16{32'h61616161}};
    blk_pad = mk_blk(32'h00000080, 32'h00000200);
    blk_abc = mk_blk(32'h80636261, 32'h00000018);

    vecs[0] = '{inst: 0, data: mk_blk(32'h00000080, 32'h0), dig: D_EMPTY, name: "empty_u1"};
    vecs[1] = '{inst: 0, data: blk_abc, dig: D_ABC, name: "abc_u1"};
    vecs[2] = '{inst: 1, data: blk_abc, dig: D_ABC, name: "abc_u2"};
    vecs[3] = '{inst: 2, data: blk_abc, dig: D_ABC, name: "abc_u4"};
    vecs[4] = '{inst: 3, data: blk_abc, dig: D_ABC, name: "abc_u8"};

    rst_n = 1'b0; valid_v = '0; dr_v = 4'hf; dv_prev = '0;
    blk_data = '0; blk_first = 1'b0; blk_last = 1'b0; iv_sel = 1'b0; iv_in = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_ready", ready_v[k], 1'b1);
      chk("reset_dvalid", dv_v[k], 1'b0);
      chk("reset_digest", dig_v[k], '0);
      chk("reset_cnt", cnt_v[k], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single-block messages across all unroll configurations
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].inst, vecs[v].data, 1'b1, 1'b1, 1'b0, '1, 1'b1, vecs[v].dig, vecs[v].name, hs1);
      wait_dv(vecs[v].inst, vecs[v].name);
      chk({vecs[v].name, "_cnt"}, cnt_v[vecs[v].inst], 32'd1);
      @(negedge clk);
      chk({vecs[v].name, "_consumed"}, dv_v[vecs[v].inst], 1'b0);
    end

    // Two-block message, second block offered immediately
    send(0, blk_a, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "a64_b1", hs1);
    chk("a64_ready_low", ready_v[0], 1'b0);
    send(0, blk_pad, 1'b0, 1'b1, 1'b1, '1, 1'b1, D_A64, "a64", hs2);
    chk("a64_throughput", hs2 - hs1, 66);
    wait_dv(0, "a64");
    chk("a64_cnt", cnt_v[0], 32'd2);
    @(negedge clk);

    // Resume from midstate via external IV
    mid = md5_model(IV_STD, blk_a);
    send(0, blk_pad, 1'b1, 1'b1, 1'b1, mid, 1'b1, D_A64, "a64_iv", hs1);
    wait_dv(0, "a64_iv");
    chk("a64_iv_cnt", cnt_v[0], 32'd1);
    @(negedge clk);

    // Back-pressure on the digest port
    dr_v[0] = 1'b0;
    send(0, blk_abc, 1'b1, 1'b1, 1'b0, '0, 1'b1, D_ABC, "abc_hold", hs1);
    wait_dv(0, "abc_hold");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (dv_v[0] !== 1'b1 || dig_v[0] !== D_ABC || ready_v[0] !== 1'b0) bad++;
    end
    chk("hold_stable", bad, 0);
    dr_v[0] = 1'b1;
    @(negedge clk);
    chk("hold_drop_valid", dv_v[0], 1'b0);
    chk("hold_ready_back", ready_v[0], 1'b1);
    chk("digest_retained", dig_v[0], D_ABC);

    // Abort mid-compute
    send(0, mk_blk(32'h00000080, 32'h0), 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, "abort", hs1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_dvalid", dv_v[0], 1'b0);
    chk("abort_ready", ready_v[0], 1'b1);
    chk("abort_cnt", cnt_v[0], '0);
    chk("abort_digest", dig_v[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    send(0, blk_abc, 1'b1, 1'b1, 1'b0, '0, 1'b1, D_ABC, "abc_resend", hs1);
    wait_dv(0, "abc_resend");
    @(negedge clk);

    // New first block abandons an open message
    send(0, blk_a, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "open", hs1);
    send(0, blk_abc, 1'b1, 1'b1, 1'b0, '0, 1'b1, D_ABC, "abc_restart", hs1);
    wait_dv(0, "abc_restart");
    chk("restart_cnt", cnt_v[0], 32'd1);
    @(negedge clk);

    // Continuation block with no open message uses the standard IV
    send(0, blk_abc, 1'b0, 1'b1, 1'b1, 128'h12345678_9abcdef0_0fedcba9_87654321, 1'b1, D_ABC,
         "abc_orphan", hs1);
    wait_dv(0, "abc_orphan");
    chk("orphan_cnt", cnt_v[0], 32'd1);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
